// File: rtl/mem_program_loader_if.sv
// Handshake and memory-port bundle between the program loader and its
// stimulus source, instruction consumer and word-addressed memory.
interface mem_program_loader_if #(
    parameter int DW = 32,
    parameter int CW = 7
);
    logic          load_start;
    logic          load_valid;
    logic          load_last;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          fetch_start;
    logic          abort;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] words_loaded;
    logic          mem_sel;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  load_start, load_valid, load_last, load_data,
        input  fetch_start, abort, instr_ready, mem_rdata,
        output load_ready, instr_valid, instr_data,
        output busy, done, overflow, words_loaded,
        output mem_sel, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output load_start, load_valid, load_last, load_data,
        output fetch_start, abort, instr_ready, mem_rdata,
        input  load_ready, instr_valid, instr_data,
        input  busy, done, overflow, words_loaded,
        input  mem_sel, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_program_loader.sv
// Loads a program stream into word-addressed memory, then fetches it back
// one word per two cycles to a valid/ready consumer.
module mem_program_loader #(
    parameter int          MEMORY_DEPTH = 64,
    parameter int          DATA_WIDTH   = 32,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic clk,
    input  logic reset,
    mem_program_loader_if.master bus
);
    localparam int AW = $clog2(MEMORY_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] IDX_MAX   = AW'(MEMORY_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(MEMORY_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FETCH,
        HOLD
    } state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         words_q, words_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic                  ivalid_q, ivalid_d;
    logic                  load_acc;
    logic                  last_fetch;
    logic                  wr_en;

    // An aborted cycle never completes the handshake, so no word is taken.
    assign bus.load_ready = (state_q == LOAD) && !bus.abort;
    assign load_acc       = bus.load_ready && bus.load_valid;
    assign last_fetch     = ({1'b0, idx_q} == (words_q - CW'(1)));
    assign wr_en          = load_acc;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        words_d  = words_q;
        instr_d  = instr_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        ivalid_d = ivalid_q;
        if (state_q != IDLE && bus.abort) begin
            state_d  = IDLE;
            ivalid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.load_start) begin
                        state_d = LOAD;
                        idx_d   = '0;
                        ovf_d   = 1'b0;
                    end else if (bus.fetch_start && words_q != '0) begin
                        state_d = FETCH;
                        idx_d   = '0;
                    end
                end
                LOAD: begin
                    if (load_acc) begin
                        // idx saturates at the last word instead of wrapping.
                        if (idx_q != IDX_MAX) begin
                            idx_d = idx_q + 1'b1;
                        end
                        if (bus.load_last) begin
                            state_d = IDLE;
                            words_d = {1'b0, idx_q} + CW'(1);
                            done_d  = 1'b1;
                        end else if (idx_q == IDX_MAX) begin
                            state_d = IDLE;
                            words_d = DEPTH_CNT;
                            ovf_d   = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    instr_d  = bus.mem_rdata;
                    ivalid_d = 1'b1;
                    state_d  = HOLD;
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        ivalid_d = 1'b0;
                        if (last_fetch) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            words_q  <= '0;
            instr_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            ivalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            words_q  <= words_d;
            instr_q  <= instr_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            ivalid_q <= ivalid_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.overflow     = ovf_q;
    assign bus.words_loaded = words_q;
    assign bus.instr_valid  = ivalid_q;
    assign bus.instr_data   = instr_q;
    assign bus.mem_we       = wr_en;
    assign bus.mem_sel      = wr_en || (state_q == FETCH);
    assign bus.mem_wdata    = bus.load_data;
    assign bus.mem_addr     = DATA_WIDTH'(BASE_ADDR)
                            + DATA_WIDTH'({idx_q, 2'b00});
endmodule

// File: tb/tb_mem_program_loader.sv
// Bench for mem_program_loader: a behavioural memory plus a word-list
// reference model drive directed and randomized load/fetch scenarios.
module tb_mem_program_loader;
    localparam int          DEPTH = 64;
    localparam int          DW    = 32;
    localparam int          CW    = 7;
    localparam int unsigned BASE  = 0;

    logic clk;
    logic rst_n;

    mem_program_loader_if #(.DW(DW), .CW(CW)) bus ();

    mem_program_loader #(
        .MEMORY_DEPTH(DEPTH),
        .DATA_WIDTH(DW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    logic [31:0] off;
    assign off = bus.mem_addr - BASE;
    assign bus.mem_rdata = mem[off[7:2]];

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          done_cnt = 0;

    always @(posedge clk) begin
        if (rst_n && bus.mem_sel && bus.mem_we) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
            mem[off[7:2]] <= bus.mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
    end

    // Reference model: the program as the stimulus source intended it.
    logic [31:0] model_mem [DEPTH];
    int          model_n = 0;

    int cmp  = 0;
    int errs = 0;

    task automatic idle_inputs();
        bus.load_start  = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_last   = 1'b0;
        bus.load_data   = '0;
        bus.fetch_start = 1'b0;
        bus.abort       = 1'b0;
        bus.instr_ready = 1'b0;
    endtask

    task automatic start_load();
        @(negedge clk);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last,
                             input int gap);
        repeat (gap) begin
            bus.load_valid = 1'b0;
            @(negedge clk);
        end
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        bus.load_last  = last;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic run_fetch(input int rdy_pct, output logic [31:0] got[$],
                             output int cyc[$], output bit timeout);
        got = {};
        cyc = {};
        timeout = 1'b0;
        @(negedge clk);
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            bus.instr_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (bus.instr_valid && bus.instr_ready) begin
                got.push_back(bus.instr_data);
                cyc.push_back(c);
            end
            if (!bus.busy) break;
            @(negedge clk);
        end
        if (bus.busy) timeout = 1'b1;
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %0h want 0", bus.busy); end
        cmp++; if (bus.done !== 1'b0) begin errs++; $display("FAIL rst_done: got %0h want 0", bus.done); end
        cmp++; if (bus.overflow !== 1'b0) begin errs++; $display("FAIL rst_ovf: got %0h want 0", bus.overflow); end
        cmp++; if (bus.words_loaded !== 7'd0) begin errs++; $display("FAIL rst_words: got %0h want 0", bus.words_loaded); end
        cmp++; if (bus.instr_valid !== 1'b0) begin errs++; $display("FAIL rst_ivalid: got %0h want 0", bus.instr_valid); end
        cmp++; if (bus.instr_data !== 32'h0) begin errs++; $display("FAIL rst_idata: got %0h want 0", bus.instr_data); end
        cmp++; if (bus.mem_addr !== BASE) begin errs++; $display("FAIL rst_addr: got %0h want %0h", bus.mem_addr, BASE); end
        cmp++; if (bus.load_ready !== 1'b0) begin errs++; $display("FAIL rst_lready: got %0h want 0", bus.load_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_fetch_ignored();
        int d0 = done_cnt;
        @(negedge clk);
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL ign_busy: got %0h want 0", bus.busy); end
        @(negedge clk);
        cmp++; if (done_cnt - d0 !== 0) begin errs++; $display("FAIL ign_done: got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_load_basic();
        logic [31:0] w [4];
        int d0 = done_cnt;
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
        wa_q = {};
        wd_q = {};
        start_load();
        for (int i = 0; i < 4; i++) begin
            send_word(w[i], i == 3, 0);
            model_mem[i] = w[i];
        end
        model_n = 4;
        @(negedge clk);
        cmp++; if (wa_q.size() !== 4) begin errs++; $display("FAIL ld_nwr: got %0d want 4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            cmp++; if (wa_q[i] !== BASE + 32'(4 * i)) begin errs++; $display("FAIL ld_addr%0d: got %0h want %0h", i, wa_q[i], BASE + 32'(4 * i)); end
            cmp++; if (wd_q[i] !== w[i]) begin errs++; $display("FAIL ld_data%0d: got %0h want %0h", i, wd_q[i], w[i]); end
        end
        cmp++; if (bus.words_loaded !== 7'd4) begin errs++; $display("FAIL ld_words: got %0d want 4", bus.words_loaded); end
        cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL ld_busy: got %0h want 0", bus.busy); end
        cmp++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL ld_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_fetch_stream();
        logic [31:0] got[$];
        int          cyc[$];
        bit          to;
        int          d0 = done_cnt;
        run_fetch(100, got, cyc, to);
        @(negedge clk);
        cmp++; if (to !== 1'b0) begin errs++; $display("FAIL fe_timeout: got %0d want 0", to); end
        cmp++; if (got.size() !== model_n) begin errs++; $display("FAIL fe_count: got %0d want %0d", got.size(), model_n); end
        for (int i = 0; i < got.size() && i < model_n; i++) begin
            cmp++; if (got[i] !== model_mem[i]) begin errs++; $display("FAIL fe_word%0d: got %0h want %0h", i, got[i], model_mem[i]); end
        end
        for (int i = 1; i < cyc.size(); i++) begin
            cmp++; if (cyc[i] - cyc[i-1] !== 2) begin errs++; $display("FAIL fe_rate%0d: got %0d want 2", i, cyc[i] - cyc[i-1]); end
        end
        cmp++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL fe_done: got %0d want 1", done_cnt - d0); end
        cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL fe_busy: got %0h want 0", bus.busy); end
    endtask

    task automatic test_hold_stall();
        logic [31:0] d;
        logic [31:0] a;
        @(negedge clk);
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        d = bus.instr_data;
        a = bus.mem_addr;
        cmp++; if (d !== model_mem[0]) begin errs++; $display("FAIL st_first: got %0h want %0h", d, model_mem[0]); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp++; if (bus.instr_valid !== 1'b1) begin errs++; $display("FAIL st_valid%0d: got %0h want 1", i, bus.instr_valid); end
            cmp++; if (bus.instr_data !== model_mem[0]) begin errs++; $display("FAIL st_data%0d: got %0h want %0h", i, bus.instr_data, model_mem[0]); end
            cmp++; if (bus.mem_addr !== a) begin errs++; $display("FAIL st_addr%0d: got %0h want %0h", i, bus.mem_addr, a); end
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL st_abort_busy: got %0h want 0", bus.busy); end
        cmp++; if (bus.instr_valid !== 1'b0) begin errs++; $display("FAIL st_abort_valid: got %0h want 0", bus.instr_valid); end
        cmp++; if (bus.words_loaded !== 7'(model_n)) begin errs++; $display("FAIL st_abort_words: got %0d want %0d", bus.words_loaded, model_n); end
    endtask

    task automatic test_overflow();
        logic [31:0] got[$];
        int          cyc[$];
        bit          to;
        logic [31:0] w;
        wa_q = {};
        wd_q = {};
        start_load();
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            model_mem[i] = w;
            send_word(w, 1'b0, $urandom_range(1));
        end
        model_n = DEPTH;
        bus.load_valid = 1'b1;
        bus.load_data  = $urandom;
        #1;
        cmp++; if (bus.load_ready !== 1'b0) begin errs++; $display("FAIL ov_ready: got %0h want 0", bus.load_ready); end
        cmp++; if (bus.mem_we !== 1'b0) begin errs++; $display("FAIL ov_we: got %0h want 0", bus.mem_we); end
        @(negedge clk);
        bus.load_valid = 1'b0;
        cmp++; if (wa_q.size() !== DEPTH) begin errs++; $display("FAIL ov_nwr: got %0d want %0d", wa_q.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < wa_q.size(); i++) begin
            cmp++; if (wd_q[i] !== model_mem[i] || wa_q[i] !== BASE + 32'(4 * i)) begin errs++; $display("FAIL ov_wr%0d: got %0h@%0h want %0h@%0h", i, wd_q[i], wa_q[i], model_mem[i], BASE + 32'(4 * i)); end
        end
        cmp++; if (bus.overflow !== 1'b1) begin errs++; $display("FAIL ov_flag: got %0h want 1", bus.overflow); end
        cmp++; if (bus.words_loaded !== 7'd64) begin errs++; $display("FAIL ov_words: got %0d want 64", bus.words_loaded); end
        run_fetch(60, got, cyc, to);
        cmp++; if (to !== 1'b0 || got.size() !== DEPTH) begin errs++; $display("FAIL ov_fetch_count: got %0d (timeout %0d) want %0d", got.size(), to, DEPTH); end
        for (int i = 0; i < got.size() && i < DEPTH; i++) begin
            cmp++; if (got[i] !== model_mem[i]) begin errs++; $display("FAIL ov_fetch%0d: got %0h want %0h", i, got[i], model_mem[i]); end
        end
    endtask

    task automatic test_start_priority();
        logic [31:0] w0;
        logic [31:0] w1;
        int d0;
        w0 = $urandom;
        w1 = $urandom;
        @(negedge clk);
        bus.load_start  = 1'b1;
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.load_start  = 1'b0;
        bus.fetch_start = 1'b0;
        d0 = done_cnt;
        cmp++; if (bus.load_ready !== 1'b1) begin errs++; $display("FAIL pr_load: got %0h want 1", bus.load_ready); end
        cmp++; if (bus.overflow !== 1'b0) begin errs++; $display("FAIL pr_ovf_clr: got %0h want 0", bus.overflow); end
        send_word(w0, 1'b0, 0);
        send_word(w1, 1'b1, 1);
        model_mem[0] = w0;
        model_mem[1] = w1;
        model_n = 2;
        @(negedge clk);
        cmp++; if (bus.words_loaded !== 7'd2) begin errs++; $display("FAIL pr_words: got %0d want 2", bus.words_loaded); end
        cmp++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL pr_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_abort_load();
        int d0 = done_cnt;
        logic [31:0] w;
        wa_q = {};
        wd_q = {};
        start_load();
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            model_mem[i] = w;
            send_word(w, 1'b0, 0);
        end
        bus.load_valid = 1'b1;
        bus.load_data  = $urandom;
        bus.abort      = 1'b1;
        #1;
        cmp++; if (bus.mem_we !== 1'b0) begin errs++; $display("FAIL ab_we: got %0h want 0", bus.mem_we); end
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.abort      = 1'b0;
        @(negedge clk);
        cmp++; if (wa_q.size() !== 2) begin errs++; $display("FAIL ab_nwr: got %0d want 2", wa_q.size()); end
        cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL ab_busy: got %0h want 0", bus.busy); end
        cmp++; if (bus.words_loaded !== 7'(model_n)) begin errs++; $display("FAIL ab_words: got %0d want %0d", bus.words_loaded, model_n); end
        cmp++; if (done_cnt - d0 !== 0) begin errs++; $display("FAIL ab_done: got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_random_loads();
        logic [31:0] got[$];
        int          cyc[$];
        bit          to;
        logic [31:0] w;
        int          n;
        int          d0;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(20, 1);
            wa_q = {};
            wd_q = {};
            d0 = done_cnt;
            start_load();
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                model_mem[i] = w;
                send_word(w, i == n - 1, $urandom_range(2));
            end
            model_n = n;
            @(negedge clk);
            cmp++; if (bus.words_loaded !== 7'(n)) begin errs++; $display("FAIL rnd%0d_words: got %0d want %0d", it, bus.words_loaded, n); end
            cmp++; if (wa_q.size() !== n) begin errs++; $display("FAIL rnd%0d_nwr: got %0d want %0d", it, wa_q.size(), n); end
            run_fetch(60, got, cyc, to);
            @(negedge clk);
            cmp++; if (to !== 1'b0 || got.size() !== n) begin errs++; $display("FAIL rnd%0d_fcount: got %0d (timeout %0d) want %0d", it, got.size(), to, n); end
            for (int i = 0; i < got.size() && i < n; i++) begin
                cmp++; if (got[i] !== model_mem[i]) begin errs++; $display("FAIL rnd%0d_w%0d: got %0h want %0h", it, i, got[i], model_mem[i]); end
            end
            cmp++; if (done_cnt - d0 !== 2) begin errs++; $display("FAIL rnd%0d_done: got %0d want 2", it, done_cnt - d0); end
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit seen = 1'b0;
        @(negedge clk);
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        bus.instr_ready = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (bus.instr_valid) seen = 1'b1;
            @(negedge clk);
        end
        cmp++; if (seen !== 1'b1) begin errs++; $display("FAIL rm_progress: got %0d want 1", seen); end
        #2;
        rst_n = 1'b0;
        #1;
        cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rm_busy: got %0h want 0", bus.busy); end
        cmp++; if (bus.instr_valid !== 1'b0) begin errs++; $display("FAIL rm_ivalid: got %0h want 0", bus.instr_valid); end
        cmp++; if (bus.instr_data !== 32'h0) begin errs++; $display("FAIL rm_idata: got %0h want 0", bus.instr_data); end
        cmp++; if (bus.words_loaded !== 7'd0) begin errs++; $display("FAIL rm_words: got %0d want 0", bus.words_loaded); end
        cmp++; if (bus.mem_addr !== BASE) begin errs++; $display("FAIL rm_addr: got %0h want %0h", bus.mem_addr, BASE); end
        cmp++; if (bus.done !== 1'b0 || bus.overflow !== 1'b0) begin errs++; $display("FAIL rm_flags: got %0h/%0h want 0/0", bus.done, bus.overflow); end
        bus.instr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rm_post_busy: got %0h want 0", bus.busy); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_idle_fetch_ignored();
        test_load_basic();
        test_fetch_stream();
        test_hold_stall();
        test_overflow();
        test_start_priority();
        test_abort_load();
        test_random_loads();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time budget");
        $fatal(1);
    end
endmodule
